// File: rtl/recirc_demux_lanes.sv
// recirc_demux_lanes: registered per-lane demultiplexer for the recirculation
// stage. A lane's word goes to the main path (toward the lane mux) when its
// valid bit is set. Otherwise, or when probe_force is set, it goes to the
// probe path. Routing has one cycle of latency and no combinational
// input-to-output path. Per-lane saturating counters record how many words
// went each way.
module recirc_demux_lanes #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES-1:0]       probe_force,
  input  logic                   cnt_clr,
  output logic [LANES*WIDTH-1:0] data_mux,
  output logic [LANES-1:0]       valid_mux,
  output logic [LANES*WIDTH-1:0] data_probe,
  output logic [LANES-1:0]       valid_probe,
  output logic [LANES*CNT_W-1:0] mux_cnt,
  output logic [LANES*CNT_W-1:0] probe_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [LANES*WIDTH-1:0] data_mux_q, data_mux_d;
  logic [LANES*WIDTH-1:0] data_probe_q, data_probe_d;
  logic [LANES-1:0]       valid_mux_q, valid_mux_d;
  logic [LANES-1:0]       valid_probe_q, valid_probe_d;
  logic [LANES*CNT_W-1:0] mux_cnt_q, mux_cnt_d;
  logic [LANES*CNT_W-1:0] probe_cnt_q, probe_cnt_d;

  logic [LANES-1:0] take_mux;
  logic [LANES-1:0] take_probe;

  // Routing decision per lane. Disable wins first, then force, then valid.
  always_comb begin
    take_mux   = '0;
    take_probe = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        if (probe_force[i]) begin
          take_probe[i] = 1'b1;
        end else if (in_valid[i]) begin
          take_mux[i] = 1'b1;
        end else begin
          take_probe[i] = 1'b1;
        end
      end
    end
  end

  // Next-state data and valid. The path that is not selected holds its data.
  always_comb begin
    data_mux_d    = data_mux_q;
    data_probe_d  = data_probe_q;
    valid_mux_d   = take_mux;
    valid_probe_d = take_probe;
    for (int i = 0; i < LANES; i++) begin
      if (take_mux[i]) begin
        data_mux_d[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
      end
      if (take_probe[i]) begin
        data_probe_d[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state counters. They saturate rather than wrap. A clear beats an
  // increment, so the word routed in the clear cycle is not counted.
  always_comb begin
    mux_cnt_d   = mux_cnt_q;
    probe_cnt_d = probe_cnt_q;
    for (int i = 0; i < LANES; i++) begin
      if (cnt_clr) begin
        mux_cnt_d[i*CNT_W +: CNT_W]   = '0;
        probe_cnt_d[i*CNT_W +: CNT_W] = '0;
      end else begin
        if (take_mux[i] && (mux_cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          mux_cnt_d[i*CNT_W +: CNT_W] = mux_cnt_q[i*CNT_W +: CNT_W] + CNT_ONE;
        end
        if (take_probe[i] && (probe_cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
          probe_cnt_d[i*CNT_W +: CNT_W] = probe_cnt_q[i*CNT_W +: CNT_W] + CNT_ONE;
        end
      end
    end
  end

  // State registers. An asynchronous reset drops all outputs immediately.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_mux_q    <= '0;
      data_probe_q  <= '0;
      valid_mux_q   <= '0;
      valid_probe_q <= '0;
      mux_cnt_q     <= '0;
      probe_cnt_q   <= '0;
    end else begin
      data_mux_q    <= data_mux_d;
      data_probe_q  <= data_probe_d;
      valid_mux_q   <= valid_mux_d;
      valid_probe_q <= valid_probe_d;
      mux_cnt_q     <= mux_cnt_d;
      probe_cnt_q   <= probe_cnt_d;
    end
  end

  assign data_mux    = data_mux_q;
  assign valid_mux   = valid_mux_q;
  assign data_probe  = data_probe_q;
  assign valid_probe = valid_probe_q;
  assign mux_cnt     = mux_cnt_q;
  assign probe_cnt   = probe_cnt_q;

endmodule

// File: tb/tb_recirc_demux_lanes.sv
// Testbench for recirc_demux_lanes. It uses a lane-level reference model and
// a scoreboard queue, a table of directed vectors, and hand-written sequences
// for saturation, clear and mid-cycle reset.
module tb_recirc_demux_lanes;
  localparam int L  = 4;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_L;
  logic [L*W-1:0]   in_data;
  logic [L-1:0]     in_valid, lane_en, probe_force;
  logic             cnt_clr;
  logic [L*W-1:0]   data_mux, data_probe;
  logic [L-1:0]     valid_mux, valid_probe;
  logic [L*CW-1:0]  mux_cnt, probe_cnt;

  recirc_demux_lanes #(.LANES(L), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_L(reset_L), .in_data(in_data), .in_valid(in_valid),
    .lane_en(lane_en), .probe_force(probe_force), .cnt_clr(cnt_clr),
    .data_mux(data_mux), .valid_mux(valid_mux), .data_probe(data_probe),
    .valid_probe(valid_probe), .mux_cnt(mux_cnt), .probe_cnt(probe_cnt)
  );

  typedef struct {
    logic [L*W-1:0]  dm;
    logic [L-1:0]    vm;
    logic [L*W-1:0]  dp;
    logic [L-1:0]    vp;
    logic [L*CW-1:0] mc;
    logic [L*CW-1:0] pc;
  } exp_t;

  typedef struct {
    logic [L*W-1:0] data;
    logic [L-1:0]   valid;
    logic [L-1:0]   en;
    logic [L-1:0]   frc;
    logic           clr;
    logic [L-1:0]   exp_vm;
    logic [L-1:0]   exp_vp;
  } vec_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  // reference model state, one entry per lane
  logic [W-1:0] m_dm [L];
  logic [W-1:0] m_dp [L];
  int           m_mc [L];
  int           m_pc [L];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_dm[i] = '0; m_dp[i] = '0; m_mc[i] = 0; m_pc[i] = 0;
    end
    sbq.delete();
  endtask

  // Compute the expected outputs for the current inputs and queue them.
  task automatic predict();
    exp_t e;
    logic [W-1:0] word;
    bit tm, tp;
    e.vm = '0; e.vp = '0;
    for (int i = 0; i < L; i++) begin
      word = in_data[i*W +: W];
      tm = 1'b0; tp = 1'b0;
      if (!lane_en[i]) begin
        tm = 1'b0;
      end else if (probe_force[i]) begin
        m_dp[i] = word; tp = 1'b1;
      end else if (in_valid[i]) begin
        m_dm[i] = word; tm = 1'b1;
      end else begin
        m_dp[i] = word; tp = 1'b1;
      end
      if (cnt_clr) begin
        m_mc[i] = 0; m_pc[i] = 0;
      end else begin
        if (tm && m_mc[i] < CMAX) m_mc[i]++;
        if (tp && m_pc[i] < CMAX) m_pc[i]++;
      end
      e.vm[i] = tm;
      e.vp[i] = tp;
      e.dm[i*W +: W]   = m_dm[i];
      e.dp[i*W +: W]   = m_dp[i];
      e.mc[i*CW +: CW] = m_mc[i][CW-1:0];
      e.pc[i*CW +: CW] = m_pc[i][CW-1:0];
    end
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [L*W-1:0] d, input logic [L-1:0] v,
                       input logic [L-1:0] en, input logic [L-1:0] f, input logic clr);
    in_data = d; in_valid = v; lane_en = en; probe_force = f; cnt_clr = clr;
  endtask

  // Queue the prediction, clock once, sample 1ns after the edge and compare.
  task automatic step_check();
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("data_mux", data_mux, e.dm);
      chk("valid_mux", valid_mux, e.vm);
      chk("data_probe", data_probe, e.dp);
      chk("valid_probe", valid_probe, e.vp);
      chk("mux_cnt", mux_cnt, e.mc);
      chk("probe_cnt", probe_cnt, e.pc);
      chk("excl_valid", valid_mux & valid_probe, '0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dm"}, data_mux, '0);
    chk({tag, "_vm"}, valid_mux, '0);
    chk({tag, "_dp"}, data_probe, '0);
    chk({tag, "_vp"}, valid_probe, '0);
    chk({tag, "_mc"}, mux_cnt, '0);
    chk({tag, "_pc"}, probe_cnt, '0);
  endtask

  vec_t vt [8];

  initial begin
    vt[0] = '{32'h44332211, 4'b1111, 4'hF, 4'b0000, 1'b0, 4'b1111, 4'b0000};
    vt[1] = '{32'hDDCCBBAA, 4'b0101, 4'hF, 4'b0000, 1'b0, 4'b0101, 4'b1010};
    vt[2] = '{32'h1122335A, 4'b1111, 4'hF, 4'b0001, 1'b0, 4'b1110, 4'b0001};
    vt[3] = '{32'h01020304, 4'b1010, 4'hE, 4'b0000, 1'b0, 4'b1010, 4'b0100};
    vt[4] = '{32'h05060708, 4'b0101, 4'hE, 4'b0000, 1'b0, 4'b0100, 4'b1010};
    vt[5] = '{32'h090A0B0C, 4'b1111, 4'hE, 4'b0000, 1'b0, 4'b1110, 4'b0000};
    vt[6] = '{32'hFFFFFFFF, 4'b1111, 4'h0, 4'b1111, 1'b0, 4'b0000, 4'b0000};
    vt[7] = '{32'h77665544, 4'b0011, 4'hF, 4'b0000, 1'b1, 4'b0011, 4'b1100};

    reset_L = 1'b0;
    drive('0, '0, '0, '0, 1'b0);
    model_reset();
    #12;
    chk_all_zero("reset");

    @(posedge clk); #1;
    reset_L = 1'b1;

    // directed table
    for (int k = 0; k < 8; k++) begin
      drive(vt[k].data, vt[k].valid, vt[k].en, vt[k].frc, vt[k].clr);
      step_check();
      chk("tbl_vm", valid_mux, vt[k].exp_vm);
      chk("tbl_vp", valid_probe, vt[k].exp_vp);
      if (k == 0) chk("first_mux_cnt", mux_cnt, 16'h1111);
      if (k == 1) chk("probe_hold_l0", data_probe[7:0], 8'h00);
      if (k == 2) chk("force_dp_l0", data_probe[7:0], 8'h5A);
    end

    // saturation, then clear with a routed word
    drive(32'h0, 4'b0000, 4'h0, 4'b0000, 1'b1);
    step_check();
    for (int k = 0; k < 20; k++) begin
      drive({4{k[7:0]}}, 4'b1111, 4'h1, 4'b0000, 1'b0);
      step_check();
    end
    chk("sat_mux_cnt_l0", mux_cnt[3:0], 4'hF);
    drive(32'h000000C3, 4'b0001, 4'h1, 4'b0000, 1'b1);
    step_check();
    chk("clr_mux_cnt_l0", mux_cnt[3:0], 4'h0);
    chk("clr_vm_l0", valid_mux[0], 1'b1);
    chk("clr_dm_l0", data_mux[7:0], 8'hC3);
    drive(32'h000000C4, 4'b0001, 4'h1, 4'b0000, 1'b0);
    step_check();
    chk("post_clr_cnt_l0", mux_cnt[3:0], 4'h1);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      drive($urandom, 4'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
      step_check();
    end

    // mid-cycle reset while valids are high
    drive(32'hA1B2C3D4, 4'b1111, 4'hF, 4'b0000, 1'b0);
    step_check();
    #2;
    reset_L = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("held_rst");
    reset_L = 1'b1;
    drive(32'h0F0E0D0C, 4'b1111, 4'hF, 4'b0000, 1'b0);
    #1;
    chk("no_comb_path", valid_mux, 4'b0000);
    step_check();
    chk("rel_dm", data_mux, 32'h0F0E0D0C);
    chk("rel_cnt", mux_cnt, 16'h1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
